uart_tx_cfg: RTL

Parametrised UART transmitter and successor to the fixed 8N1 transmitter. It adds a runtime baud divisor, runtime data length (5..DATA_BITS), optional even/odd parity, one or two stop bits, and a ready/valid input handshake with back-to-back frame support. It sits between command/telemetry FSMs and the board Tx pin.

---
 rtl/uart_tx_cfg.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter with ready/valid input
// Divisor, length, parity and stop count are clamped and latched at accept.
module uart_tx_cfg #(
  parameter int DATA_BITS = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] i_clks_per_bit,
  input  logic [3:0]           i_num_bits,
  input  logic [1:0]           i_parity,
  input  logic                 i_two_stop,
  input  logic                 i_data_avail,
  input  logic [DATA_BITS-1:0] i_data_byte,
  output logic                 o_ready,
  output logic                 o_active,
  output logic                 o_tx,
  output logic                 o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_t;

  state_t               state, state_next;
  logic [DIV_WIDTH-1:0] bit_cnt, cnt_next;
  logic [3:0]           bit_idx, idx_next;
  logic [DIV_WIDTH-1:0] cpb_q;
  logic [3:0]           nb_q;
  logic                 par_en_q, par_q, two_stop_q;
  logic [DATA_BITS-1:0] data_sh, data_next;
  logic                 tx_q, tx_next, done_q;

  logic [DIV_WIDTH-1:0] cpb_clamp;
  logic [3:0]           nb_clamp;
  logic [DATA_BITS-1:0] data_masked;
  logic                 accept, bit_end;

  assign cpb_clamp = (i_clks_per_bit < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : i_clks_per_bit;
  assign nb_clamp  = (i_num_bits < 4'd5)             ? 4'd5 :
                     (i_num_bits > 4'(DATA_BITS))    ? 4'(DATA_BITS) : i_num_bits;

  // Unused upper bits are zeroed so the parity XOR covers only transmitted bits.
  always_comb begin
    data_masked = '0;
    for (int i = 0; i < DATA_BITS; i++) begin
      data_masked[i] = (i < int'(nb_clamp)) ? i_data_byte[i] : 1'b0;
    end
  end

  assign accept  = i_data_avail && (state == S_IDLE);
  assign bit_end = (bit_cnt == cpb_q - DIV_WIDTH'(1));

  always_comb begin
    state_next = state;
    cnt_next   = bit_cnt;
    idx_next   = bit_idx;
    data_next  = data_sh;
    if (state == S_IDLE) begin
      if (accept) begin
        state_next = S_START;
        cnt_next   = '0;
        idx_next   = '0;
      end
    end else if (bit_end) begin
      cnt_next = '0;
      case (state)
        S_START: begin
          state_next = S_DATA;
          idx_next   = '0;
        end
        S_DATA: begin
          if (bit_idx == nb_q - 4'd1) begin
            state_next = par_en_q ? S_PARITY : S_STOP1;
          end else begin
            idx_next  = bit_idx + 4'd1;
            data_next = data_sh >> 1;
          end
        end
        S_PARITY: state_next = S_STOP1;
        S_STOP1:  state_next = two_stop_q ? S_STOP2 : S_IDLE;
        default:  state_next = S_IDLE;
      endcase
    end else begin
      cnt_next = bit_cnt + DIV_WIDTH'(1);
    end
  end

  // Line level is chosen from the next state so o_tx can be a plain register.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = data_next[0];
      S_PARITY: tx_next = par_q;
      default:  tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      cpb_q      <= '0;
      nb_q       <= '0;
      par_en_q   <= 1'b0;
      par_q      <= 1'b0;
      two_stop_q <= 1'b0;
      data_sh    <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state   <= state_next;
      bit_cnt <= cnt_next;
      bit_idx <= idx_next;
      tx_q    <= tx_next;
      done_q  <= (state != S_IDLE) && (state_next == S_IDLE);
      if (accept) begin
        cpb_q      <= cpb_clamp;
        nb_q       <= nb_clamp;
        par_en_q   <= (i_parity == 2'b01) || (i_parity == 2'b10);
        par_q      <= (^data_masked) ^ (i_parity == 2'b10);
        two_stop_q <= i_two_stop;
        data_sh    <= data_masked;
      end else begin
        data_sh <= data_next;
      end
    end
  end

  assign o_ready  = (state == S_IDLE);
  assign o_active = (state != S_IDLE);
  assign o_tx     = tx_q;
  assign o_done   = done_q;

endmodule
